// File: rtl/dvi_pattern_source.sv
// Raster timing generator with selectable test patterns for the DVI path.
// A single pixel-clock domain. The h/v counters are registered into every
// output with one cycle of latency, so sync, de, RGB, coordinates and
// frame_start all leave the block aligned with each other.
module dvi_pattern_source #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int CW       = 8,
  parameter int CHK_LOG2 = 5,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW      = $clog2(H_TOTAL),
  localparam int VW      = $clog2(V_TOTAL)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            enable,
  input  logic [2:0]      mode,
  input  logic [3*CW-1:0] fg_color,
  output logic            hsync,
  output logic            vsync,
  output logic            de,
  output logic [CW-1:0]   red,
  output logic [CW-1:0]   green,
  output logic [CW-1:0]   blue,
  output logic [HW-1:0]   pixel_x,
  output logic [VW-1:0]   pixel_y,
  output logic            frame_start
);

  // Range bounds carry one extra bit so a sync that ends exactly at the
  // line/frame total still compares correctly.
  localparam int HX = HW + 1;
  localparam int VX = VW + 1;

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [HX-1:0] H_ACT_X  = HX'(H_ACTIVE);
  localparam logic [HX-1:0] HS_BEG_X = HX'(H_ACTIVE + H_FP);
  localparam logic [HX-1:0] HS_END_X = HX'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VX-1:0] V_ACT_X  = VX'(V_ACTIVE);
  localparam logic [VX-1:0] VS_BEG_X = VX'(V_ACTIVE + V_FP);
  localparam logic [VX-1:0] VS_END_X = VX'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic HS_ACT = (HS_POL != 0);
  localparam logic VS_ACT = (VS_POL != 0);

  // Bars are tracked with a pixel-in-bar counter instead of dividing x.
  // A degenerate narrow raster still gets one-pixel bars.
  localparam int BAR_W_RAW = H_ACTIVE / 8;
  localparam int BAR_W     = (BAR_W_RAW < 1) ? 1 : BAR_W_RAW;
  localparam logic [HW-1:0] BAR_LAST = HW'(BAR_W - 1);

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [2:0]    mode_q, mode_d;
  logic [7:0]    frame_q, frame_d;
  logic [HW-1:0] bar_cnt_q, bar_cnt_d;
  logic [2:0]    bar_idx_q, bar_idx_d;

  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          de_q, de_d;
  logic [CW-1:0] red_q, red_d;
  logic [CW-1:0] green_q, green_d;
  logic [CW-1:0] blue_q, blue_d;
  logic [HW-1:0] pixel_x_q, pixel_x_d;
  logic [VW-1:0] pixel_y_q, pixel_y_d;
  logic          frame_start_q, frame_start_d;

  logic          at_origin, h_wrap, v_wrap;
  logic          active, hs_on, vs_on, chk;
  logic [2:0]    mode_eff;
  logic [CW-1:0] fg_r, fg_g, fg_b;
  logic [CW-1:0] pat_r, pat_g, pat_b;
  logic [CW-1:0] x_cw, y_cw, fr_cw;

  // Position decode for the pixel currently held in the counters.
  always_comb begin
    at_origin = (h_q == '0) && (v_q == '0);
    h_wrap    = (h_q == H_LAST);
    v_wrap    = (v_q == V_LAST);
    active    = ({1'b0, h_q} < H_ACT_X) && ({1'b0, v_q} < V_ACT_X);
    hs_on     = ({1'b0, h_q} >= HS_BEG_X) && ({1'b0, h_q} < HS_END_X);
    vs_on     = ({1'b0, v_q} >= VS_BEG_X) && ({1'b0, v_q} < VS_END_X);
    // The mode loaded at (0,0) must already colour pixel (0,0).
    mode_eff  = at_origin ? mode : mode_q;
  end

  // Counter, mode-register, frame-counter and bar-tracker next state.
  always_comb begin
    h_d       = h_q;
    v_d       = v_q;
    mode_d    = mode_q;
    frame_d   = frame_q;
    bar_cnt_d = bar_cnt_q;
    bar_idx_d = bar_idx_q;
    if (enable) begin
      if (at_origin) begin
        mode_d = mode;
      end
      if (h_wrap) begin
        h_d       = '0;
        bar_cnt_d = '0;
        bar_idx_d = '0;
        if (v_wrap) begin
          v_d     = '0;
          frame_d = frame_q + 8'd1;
        end else begin
          v_d = v_q + 1'b1;
        end
      end else begin
        h_d = h_q + 1'b1;
        if (bar_cnt_q == BAR_LAST) begin
          bar_cnt_d = '0;
          if (bar_idx_q != 3'd7) begin
            bar_idx_d = bar_idx_q + 3'd1;
          end
        end else begin
          bar_cnt_d = bar_cnt_q + 1'b1;
        end
      end
    end
  end

  // Pattern generator for the current pixel, before blanking.
  always_comb begin
    fg_r  = fg_color[3*CW-1 -: CW];
    fg_g  = fg_color[2*CW-1 -: CW];
    fg_b  = fg_color[CW-1 -: CW];
    x_cw  = CW'(h_q);
    y_cw  = CW'(v_q);
    fr_cw = CW'(frame_q);
    chk   = h_q[CHK_LOG2] ^ v_q[CHK_LOG2];
    pat_r = '0;
    pat_g = '0;
    pat_b = '0;
    case (mode_eff)
      3'd0: begin
        pat_r = fg_r;
        pat_g = fg_g;
        pat_b = fg_b;
      end
      3'd1: begin
        // white, yellow, cyan, green, magenta, red, blue, black
        pat_r = {CW{~bar_idx_q[1]}};
        pat_g = {CW{~bar_idx_q[2]}};
        pat_b = {CW{~bar_idx_q[0]}};
      end
      3'd2: begin
        pat_r = chk ? ~fg_r : fg_r;
        pat_g = chk ? ~fg_g : fg_g;
        pat_b = chk ? ~fg_b : fg_b;
      end
      3'd3: begin
        pat_r = x_cw;
        pat_g = x_cw;
        pat_b = x_cw;
      end
      3'd4: begin
        pat_r = y_cw;
        pat_g = y_cw;
        pat_b = y_cw;
      end
      3'd5: begin
        pat_r = fr_cw;
        pat_g = fr_cw;
        pat_b = fr_cw;
      end
      default: begin
        pat_r = '0;
        pat_g = '0;
        pat_b = '0;
      end
    endcase
  end

  // Output next state; a frozen raster blanks and idles the syncs while
  // the coordinate outputs keep the last presented pixel.
  always_comb begin
    hsync_d       = ~HS_ACT;
    vsync_d       = ~VS_ACT;
    de_d          = 1'b0;
    red_d         = '0;
    green_d       = '0;
    blue_d        = '0;
    frame_start_d = 1'b0;
    pixel_x_d     = pixel_x_q;
    pixel_y_d     = pixel_y_q;
    if (enable) begin
      hsync_d       = hs_on ? HS_ACT : ~HS_ACT;
      vsync_d       = vs_on ? VS_ACT : ~VS_ACT;
      de_d          = active;
      frame_start_d = at_origin;
      pixel_x_d     = h_q;
      pixel_y_d     = v_q;
      if (active) begin
        red_d   = pat_r;
        green_d = pat_g;
        blue_d  = pat_b;
      end
    end
  end

  // State and output registers; reset forces every output immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_q           <= '0;
      v_q           <= '0;
      mode_q        <= '0;
      frame_q       <= '0;
      bar_cnt_q     <= '0;
      bar_idx_q     <= '0;
      hsync_q       <= ~HS_ACT;
      vsync_q       <= ~VS_ACT;
      de_q          <= 1'b0;
      red_q         <= '0;
      green_q       <= '0;
      blue_q        <= '0;
      pixel_x_q     <= '0;
      pixel_y_q     <= '0;
      frame_start_q <= 1'b0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      mode_q        <= mode_d;
      frame_q       <= frame_d;
      bar_cnt_q     <= bar_cnt_d;
      bar_idx_q     <= bar_idx_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      red_q         <= red_d;
      green_q       <= green_d;
      blue_q        <= blue_d;
      pixel_x_q     <= pixel_x_d;
      pixel_y_q     <= pixel_y_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign red         = red_q;
  assign green       = green_q;
  assign blue        = blue_q;
  assign pixel_x     = pixel_x_q;
  assign pixel_y     = pixel_y_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_dvi_pattern_source.sv
// Bench for dvi_pattern_source on a 24x12 raster.
module tb_dvi_pattern_source;

  localparam int HA = 16, HFP = 2, HSY = 3, HBP = 3;
  localparam int VA = 8, VFP = 1, VSY = 2, VBP = 1;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b1;
  logic [2:0]  mode = 3'd0;
  logic [23:0] fg_color = 24'h123456;
  logic        hsync, vsync, de, frame_start;
  logic [7:0]  red, green, blue;
  logic [4:0]  pixel_x;
  logic [3:0]  pixel_y;

  dvi_pattern_source #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .HS_POL(0), .VS_POL(0), .CW(8), .CHK_LOG2(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .mode(mode),
    .fg_color(fg_color), .hsync(hsync), .vsync(vsync), .de(de),
    .red(red), .green(green), .blue(blue),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        de, hs, vs, fs;
    logic [23:0] rgb;
    int          x, y;
    logic        chk_pos;
  } exp_t;

  typedef struct {
    logic [2:0]  mode;
    logic [23:0] fg;
    int          x, y;
    logic [23:0] rgb;
  } vec_t;

  exp_t sbq[$];

  int tests = 0;
  int fails = 0;
  int mh = 0, mv = 0, mfr = 0;
  logic [2:0] mmode = 3'd0;
  int last_x = -1, last_y = -1, last_mode = -1;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  function automatic logic [23:0] pat(input logic [2:0] m, input int x, input int y,
                                      input int fr, input logic [23:0] fg);
    logic [23:0] bars [8];
    logic [7:0]  t;
    int b;
    bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    case (m)
      3'd0: return fg;
      3'd1: begin
        b = x / (HA / 8);
        if (b > 7) b = 7;
        return bars[b];
      end
      3'd2: return (((x / 4) + (y / 4)) % 2 != 0) ? ~fg : fg;
      3'd3: begin t = 8'(x); return {t, t, t}; end
      3'd4: begin t = 8'(y); return {t, t, t}; end
      3'd5: begin t = 8'(fr); return {t, t, t}; end
      default: return 24'h0;
    endcase
  endfunction

  // One pixel clock: predict, push, clock, pop and compare, advance model.
  task automatic step();
    exp_t e;
    logic [2:0] pm;
    pm = (mh == 0 && mv == 0) ? mode : mmode;
    if (enable) begin
      e.de = (mh < HA) && (mv < VA);
      e.hs = !((mh >= HA + HFP) && (mh < HA + HFP + HSY));
      e.vs = !((mv >= VA + VFP) && (mv < VA + VFP + VSY));
      e.fs = (mh == 0) && (mv == 0);
      e.rgb = e.de ? pat(pm, mh, mv, mfr, fg_color) : 24'h0;
      e.x = mh;
      e.y = mv;
      e.chk_pos = 1'b1;
    end else begin
      e.de = 1'b0; e.hs = 1'b1; e.vs = 1'b1; e.fs = 1'b0;
      e.rgb = 24'h0; e.x = 0; e.y = 0; e.chk_pos = 1'b0;
    end
    sbq.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    e = sbq.pop_front();
    check($sformatf("out(%0d,%0d) de/hs/vs/fs/rgb", e.x, e.y),
          32'({de, hsync, vsync, frame_start, red, green, blue}),
          32'({e.de, e.hs, e.vs, e.fs, e.rgb}));
    if (e.chk_pos)
      check($sformatf("out(%0d,%0d) position", e.x, e.y),
            32'({pixel_x, pixel_y}), 32'({5'(e.x), 4'(e.y)}));
    if (enable) begin
      last_x = mh; last_y = mv; last_mode = int'(pm);
      if (mh == 0 && mv == 0) mmode = mode;
      if (mh == HT - 1) begin
        mh = 0;
        if (mv == VT - 1) begin
          mv = 0;
          mfr = (mfr + 1) % 256;
        end else mv++;
      end else mh++;
    end
  endtask

  // Advance until the pixel just presented is (x,y) under the given mode.
  task automatic goto_out(input int x, input int y, input int want_mode, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      step();
      if (last_x == x && last_y == y && last_mode == want_mode) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL goto(%0d,%0d,mode %0d): timeout", x, y, want_mode);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, " outs"}, 32'({de, hsync, vsync, frame_start, red, green, blue}),
          32'({1'b0, 1'b1, 1'b1, 1'b0, 24'h0}));
    check({tag, " pos"}, 32'({pixel_x, pixel_y}), 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt [$];
    bit ok;
    int n_de, n_vs, n_hs, n_fs, last_fs, gap;

    vt.push_back('{3'd1, 24'h0, 0, 0, 24'hFFFFFF});
    vt.push_back('{3'd1, 24'h0, 1, 0, 24'hFFFFFF});
    vt.push_back('{3'd1, 24'h0, 2, 0, 24'hFFFF00});
    vt.push_back('{3'd1, 24'h0, 4, 0, 24'h00FFFF});
    vt.push_back('{3'd1, 24'h0, 6, 1, 24'h00FF00});
    vt.push_back('{3'd1, 24'h0, 8, 2, 24'hFF00FF});
    vt.push_back('{3'd1, 24'h0, 11, 3, 24'hFF0000});
    vt.push_back('{3'd1, 24'h0, 12, 4, 24'h0000FF});
    vt.push_back('{3'd1, 24'h0, 14, 5, 24'h000000});
    vt.push_back('{3'd1, 24'h0, 15, 7, 24'h000000});
    vt.push_back('{3'd2, 24'hFF0000, 0, 0, 24'hFF0000});
    vt.push_back('{3'd2, 24'hFF0000, 4, 0, 24'h00FFFF});
    vt.push_back('{3'd2, 24'hFF0000, 4, 4, 24'hFF0000});
    vt.push_back('{3'd2, 24'hFF0000, 0, 4, 24'h00FFFF});
    vt.push_back('{3'd2, 24'hFF0000, 3, 3, 24'hFF0000});
    vt.push_back('{3'd3, 24'h0, 5, 1, 24'h050505});
    vt.push_back('{3'd3, 24'h0, 15, 7, 24'h0F0F0F});
    vt.push_back('{3'd4, 24'h0, 3, 6, 24'h060606});
    vt.push_back('{3'd6, 24'hABCDEF, 2, 2, 24'h000000});
    vt.push_back('{3'd7, 24'hABCDEF, 9, 5, 24'h000000});
    vt.push_back('{3'd0, 24'h123456, 10, 7, 24'h123456});

    // Held in reset across edges.
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset_hold");

    // Release and run two frames of solid colour, gathering raster stats.
    reset_n = 1'b1;
    n_de = 0; n_vs = 0; n_hs = 0; n_fs = 0; last_fs = -1; gap = 0;
    for (int i = 0; i < 2 * HT * VT; i++) begin
      step();
      if (de) n_de++;
      if (!vsync) n_vs++;
      if (!hsync) n_hs++;
      if (frame_start) begin
        if (last_fs >= 0) gap = cyc - last_fs;
        last_fs = cyc;
        n_fs++;
      end
    end
    check("frame_start count", 32'(n_fs), 32'd2);
    check("frame_start period", 32'(gap), 32'd288);
    check("de cycles", 32'(n_de), 32'd256);
    check("vsync low cycles", 32'(n_vs), 32'd96);
    check("hsync low cycles", 32'(n_hs), 32'd72);

    // Table of spot pixels per mode.
    for (int i = 0; i < vt.size(); i++) begin
      mode = vt[i].mode;
      fg_color = vt[i].fg;
      goto_out(vt[i].x, vt[i].y, int'(vt[i].mode), ok);
      if (ok)
        check($sformatf("vec%0d mode%0d (%0d,%0d) rgb", i, vt[i].mode, vt[i].x, vt[i].y),
              32'({red, green, blue}), 32'(vt[i].rgb));
    end

    // Mid-frame mode change only lands at the next frame.
    mode = 3'd0;
    fg_color = 24'h123456;
    goto_out(5, 3, 0, ok);
    mode = 3'd3;
    goto_out(10, 5, 0, ok);
    if (ok) check("late mode same frame", 32'({red, green, blue}), 32'h123456);
    goto_out(10, 5, 3, ok);
    if (ok) check("late mode next frame", 32'({red, green, blue}), 32'h0A0A0A);

    // Freeze for ten cycles with (7,2) next in line.
    goto_out(6, 2, 3, ok);
    enable = 1'b0;
    repeat (10) step();
    check("freeze outs", 32'({de, hsync, vsync, frame_start, red, green, blue}),
          32'({1'b0, 1'b1, 1'b1, 1'b0, 24'h0}));
    enable = 1'b1;
    step();
    check("resume position", 32'({pixel_x, pixel_y}), 32'({5'd7, 4'd2}));
    check("resume de/rgb", 32'({de, red, green, blue}), 32'({1'b1, 24'h070707}));

    // Asynchronous reset in the middle of a sync pulse.
    goto_out(19, 4, 3, ok);
    #3;
    reset_n = 1'b0;
    #1;
    check_reset("async_reset");
    sbq.delete();
    mh = 0; mv = 0; mfr = 0; mmode = 3'd0;
    last_x = -1; last_y = -1; last_mode = -1;
    @(posedge clk);
    #1;
    check_reset("reset_edge");
    #2;
    reset_n = 1'b1;
    mode = 3'd5;
    step();
    check("restart frame_start", 32'({frame_start, de, pixel_x, pixel_y}),
          32'({1'b1, 1'b1, 9'd0}));
    repeat (2 * HT * VT) step();
    goto_out(3, 3, 5, ok);
    if (ok) check("animated frame 2", 32'({red, green, blue}), 32'h020202);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dvi_pattern_source.md
# dvi_pattern_source

Parametrised video source for the DVI path. It generates programmable raster timing (hsync, vsync, data enable) together with selectable test-pattern RGB data, all in one pixel-clock domain. Its outputs feed the three TMDS encoders directly. It replaces the fixed-timing, switch-coloured source with run-time pattern modes, configurable sync polarity, per-pixel coordinates and a frame-start marker.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch, sync, back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical front porch, sync, back porch (lines)
- HS_POL / VS_POL, 0 / 0, sync active level (0 = active-low)
- CW, 8, bits per colour channel
- CHK_LOG2, 5, checkerboard square size = 2^CHK_LOG2 pixels
- clk  in  1  pixel clock; one clock, all logic on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  1 = raster advances; 0 = freeze
- mode  in  3  pattern select, sampled at frame start
- fg_color  in  3*CW  {R,G,B} foreground colour, sampled every cycle
- hsync, vsync, de  out  1 each  registered sync and data-enable
- red, green, blue  out  CW each  registered pixel data
- pixel_x  out  clog2(H_TOTAL)  horizontal position of the current output pixel
- pixel_y  out  clog2(V_TOTAL)  vertical position of the current output pixel
- frame_start  out  1  one-cycle pulse with pixel (0,0)

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Line order is active, then front porch, then sync, then back porch. Frame order is the same.
- h_cnt wraps H_TOTAL-1 -> 0. On that wrap, v_cnt increments, and v_cnt wraps V_TOTAL-1 -> 0.
- de = (h < H_ACTIVE) && (v < V_ACTIVE).
- hsync is active for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
- vsync is active for whole lines v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC). It changes only together with h = 0.
- Active level of each sync = its POL parameter. The inactive level is its complement.
- The mode register loads from `mode` only on the cycle the counters are at (0,0). A mid-frame change therefore takes effect at the next frame.
- Frame counter: 8 bits. Increments at each frame wrap and wraps 255 -> 0.
- Patterns. RGB is 0 whenever de = 0.
  - 0: solid fg_color.
  - 1: eight colour bars. BAR_W = floor(H_ACTIVE/8) and the bar index saturates at 7. Order: white, yellow, cyan, green, magenta, red, blue, black. Full scale is all-ones.
  - 2: checkerboard. x[CHK_LOG2] ^ y[CHK_LOG2] = 0 -> fg_color, else bitwise ~fg_color.
  - 3: horizontal grey ramp. R = G = B = x[CW-1:0], wrapping modulo 2^CW.
  - 4: vertical grey ramp, from y[CW-1:0].
  - 5: animated solid. R = G = B = frame counter; its low CW bits when CW < 8, zero-extended when CW > 8.
  - 6, 7: black.
- The bar index uses an incrementing sub-counter, not a divider.
- enable = 0:
  - counters, mode register and frame counter hold;
  - de = 0, RGB = 0, frame_start = 0, and both syncs are inactive.
  - When enable returns to 1, the raster resumes from the held position.

## Timing
- Reset values while reset_n = 0:
  - counters 0, mode register 0, frame counter 0;
  - de 0, RGB 0, frame_start 0, pixel_x/pixel_y 0;
  - hsync = ~HS_POL, vsync = ~VS_POL.
- Assertion of reset_n is asynchronous, and every output takes its reset value immediately.
- Release is synchronous in effect. At the first rising edge with reset_n = 1 and enable = 1, the outputs present pixel (0,0): de = 1 and frame_start = 1, and the counters advance to (1,0).
- Latency: the counter state is registered into all outputs with exactly 1 cycle of delay.
- hsync, vsync, de, RGB, pixel_x, pixel_y and frame_start are mutually aligned with no skew.
- frame_start is high for exactly 1 cycle per frame, with the output pixel at (0,0).
- A mode sampled at (0,0) already governs the RGB of pixel (0,0) on the output.
- Reset mid-line restarts the raster at (0,0). No partial sync pulse is extended.

## Test plan
Bench parameters: H_ACTIVE=16, H_FP=2, H_SYNC=3, H_BP=3 (H_TOTAL 24); V_ACTIVE=8, V_FP=1, V_SYNC=2, V_BP=1 (V_TOTAL 12); CW=8, CHK_LOG2=2, HS_POL=VS_POL=0.

- Reset release, enable=1 -> frame_start pulses every 288 cycles. de is high for 16 of every 24 cycles on lines 0-7. hsync is low on output h = 18..20. vsync is low for 48 cycles covering lines 9-10.
- mode=0, fg_color=24'h123456 -> RGB = 12/34/56 on every de cycle and 0 when de = 0.
- mode=1 -> x = 0,1 white (FF,FF,FF); x = 2,3 yellow (FF,FF,00); ...; x = 14,15 black.
- mode=2, fg_color=24'hFF0000 -> (0,0) = FF0000, (4,0) = 00FFFF, (4,4) = FF0000.
- Mode switched 0->3 at pixel (5,3) -> rest of frame stays solid. The next frame has R = G = B = x.
- enable low for 10 cycles at (7,2) -> de = 0, syncs high, RGB 0. On re-enable the output resumes at (7,2). reset_n pulsed low mid-line -> outputs go to reset values without waiting for a clock edge.
